sobel_window_fetch: RTL and testbench

Sequencer that walks a 512x384 frame buffer in raster order. For each center pixel it reads the 3x3 neighborhood from a single-port synchronous-read RAM, inserting literal zero pixels for out-of-frame taps instead of issuing reads. It presents the assembled window to the Sobel datapath through a valid/ready handshake. It sits between the frame-buffer read port and the Sobel stage, and owns that read port while busy.

---
 rtl/sobel_window_fetch.sv | 153 +++++++++++++++
 tb/tb_sobel_window_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_fetch.sv
// sobel_window_fetch: raster-order 3x3 window sequencer for the Sobel stage.
// Walks every center pixel of the frame, reads the in-frame taps from the
// frame-buffer read port (1-cycle read latency), substitutes zero for taps
// outside the frame, and presents the assembled window on win_*.
//
// Handshake: win_valid is high only in HOLD. While win_valid is high,
// win_data/win_x/win_y are held stable. A window transfers on a rising edge
// where win_valid && win_ready. win_ready has no effect outside HOLD.
module sobel_window_fetch #(
   parameter int WIDTH  = 512,
   parameter int HEIGHT = 384,
   parameter int PIX_W  = 12,
   parameter int ADDR_W = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_en,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [PIX_W-1:0]     mem_dout,
   output logic                 win_valid,
   input  logic                 win_ready,
   output logic [9*PIX_W-1:0]   win_data,
   output logic [10:0]          win_x,
   output logic [10:0]          win_y,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
   localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);

   state_t            state_q, state_d;
   logic [10:0]       x_q, x_d;
   logic [10:0]       y_q, y_d;
   logic [3:0]        k_q, k_d;
   logic              pad_prev_q;
   logic [PIX_W-1:0]  tap_q [0:8];

   logic [1:0]        col, row;
   logic              tap_pad;
   logic [10:0]       tap_x, tap_y;
   logic [ADDR_W-1:0] tap_addr;
   logic              issue;

   // Decode the tap addressed by k: its offset, whether it falls outside the frame, and its address
   always_comb begin
      col      = 2'(k_q % 4'd3);
      row      = 2'(k_q / 4'd3);
      tap_pad  = ((col == 2'd0) && (x_q == 11'd0))   ||
                 ((col == 2'd2) && (x_q == X_LAST))  ||
                 ((row == 2'd0) && (y_q == 11'd0))   ||
                 ((row == 2'd2) && (y_q == Y_LAST));
      tap_x    = (col == 2'd0) ? x_q - 11'd1 : (col == 2'd2) ? x_q + 11'd1 : x_q;
      tap_y    = (row == 2'd0) ? y_q - 11'd1 : (row == 2'd2) ? y_q + 11'd1 : y_q;
      tap_addr = ADDR_W'(tap_y) * ADDR_W'(WIDTH) + ADDR_W'(tap_x);
      issue    = (state_q == S_FETCH) && (k_q <= 4'd8) && !tap_pad;
   end

   // Next-state logic: fetch 9 taps plus one drain step, hold until accepted, advance raster
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      k_d     = k_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d     = 11'd0;
               y_d     = 11'd0;
               k_d     = 4'd0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (k_q == 4'd9) begin
               k_d     = 4'd0;
               state_d = S_HOLD;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         S_HOLD: begin
            if (win_ready) begin
               k_d = 4'd0;
               if (x_q == X_LAST) begin
                  if (y_q == Y_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     x_d     = 11'd0;
                     y_d     = y_q + 11'd1;
                     state_d = S_FETCH;
                  end
               end else begin
                  x_d     = x_q + 11'd1;
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, coordinates, tap counter and captured taps; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         x_q        <= 11'd0;
         y_q        <= 11'd0;
         k_q        <= 4'd0;
         pad_prev_q <= 1'b0;
         for (int i = 0; i < 9; i++) tap_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         k_q        <= k_d;
         pad_prev_q <= tap_pad;
         // Data for the tap issued in the previous step arrives now
         if (state_q == S_FETCH) begin
            for (int i = 0; i < 9; i++) begin
               if (k_q == 4'(i + 1)) tap_q[i] <= pad_prev_q ? '0 : mem_dout;
            end
         end
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      win_valid = (state_q == S_HOLD);
      mem_en    = issue;
      mem_addr  = issue ? tap_addr : '0;
      win_x     = x_q;
      win_y     = y_q;
      dbg_state = state_q;
      win_data  = '0;
      for (int i = 0; i < 9; i++) win_data[i*PIX_W +: PIX_W] = tap_q[i];
   end

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Bench for sobel_window_fetch: a full-size instance exercises the corner,
// row wrap, interior, backpressure and abort cases; a small 8x4 instance
// runs a complete frame to check frame timing and the done pulse.
module tb_sobel_window_fetch;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- full-size DUT ----------------
   logic          start, busy, done, mem_en, win_valid, win_ready;
   logic [17:0]   mem_addr;
   logic [11:0]   mem_dout;
   logic [107:0]  win_data;
   logic [10:0]   win_x, win_y;
   logic [1:0]    dbg_state;

   sobel_window_fetch u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .win_x(win_x), .win_y(win_y), .dbg_state(dbg_state)
   );

   // Frame buffer: pixel value = address[11:0], 1-cycle read latency
   always_ff @(posedge clk) if (mem_en) mem_dout <= mem_addr[11:0];

   // ---------------- small 8x4 DUT ----------------
   logic          s_start, s_busy, s_done, s_mem_en, s_win_valid, s_ready;
   logic [4:0]    s_mem_addr;
   logic [11:0]   s_mem_dout;
   logic [107:0]  s_win_data;
   logic [10:0]   s_win_x, s_win_y;
   logic [1:0]    s_dbg_state;

   sobel_window_fetch #(.WIDTH(8), .HEIGHT(4), .PIX_W(12), .ADDR_W(5)) u_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
      .mem_en(s_mem_en), .mem_addr(s_mem_addr), .mem_dout(s_mem_dout),
      .win_valid(s_win_valid), .win_ready(s_ready), .win_data(s_win_data),
      .win_x(s_win_x), .win_y(s_win_y), .dbg_state(s_dbg_state)
   );

   always_ff @(posedge clk) if (s_mem_en) s_mem_dout <= 12'(s_mem_addr);

   // ---------------- scoreboard ----------------
   // entry: {x[10:0], y[10:0], taps[107:0], reads[3:0], first_addr[17:0]}
   logic [151:0] exp_q[$];
   logic [151:0] exp_s_q[$];
   int n_cmp  = 0;
   int n_fail = 0;
   int n_hs   = 0;
   int n_s_hs = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference window: in-frame taps read pixel = addr[11:0], out-of-frame taps are 0
   function automatic logic [151:0] model(input int x, input int y, input int w, input int h);
      logic [107:0] d;
      logic [3:0]   nr;
      logic [17:0]  fa;
      logic         got;
      logic [10:0]  xx, yy;
      int tx, ty, a;
      d = '0; nr = '0; fa = '0; got = 1'b0;
      for (int k = 0; k < 9; k++) begin
         tx = x + (k % 3) - 1;
         ty = y + (k / 3) - 1;
         if (tx >= 0 && tx < w && ty >= 0 && ty < h) begin
            a = ty * w + tx;
            d[k*12 +: 12] = a[11:0];
            nr = nr + 4'd1;
            if (!got) begin
               fa  = a[17:0];
               got = 1'b1;
            end
         end
      end
      xx = x[10:0];
      yy = y[10:0];
      return {xx, yy, d, nr, fa};
   endfunction

   task automatic chk_window(input string tag, input logic [151:0] e, input logic [10:0] x,
                             input logic [10:0] y, input logic [107:0] d, input int nr,
                             input logic [17:0] fa);
      chk({tag, "_x"}, x, e[151:141]);
      chk({tag, "_y"}, y, e[140:130]);
      chk({tag, "_data"}, d, e[129:22]);
      chk({tag, "_reads"}, nr, e[21:18]);
      chk({tag, "_first_addr"}, fa, e[17:0]);
   endtask

   // Full-size monitor: count reads per window, pop and compare on each handshake
   int rd_cnt; logic seen; logic [17:0] fa_obs;
   always @(negedge clk) begin
      #1;
      if (dbg_state == 2'd0) begin
         rd_cnt = 0; seen = 1'b0;
      end else begin
         if (mem_en) begin
            if (!seen) begin fa_obs = mem_addr; seen = 1'b1; end
            rd_cnt++;
         end
         if (win_valid && win_ready) begin
            chk("win_queue_has_entry", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0)
               chk_window("win", exp_q.pop_front(), win_x, win_y, win_data, rd_cnt, fa_obs);
            n_hs++;
            rd_cnt = 0; seen = 1'b0;
         end
      end
   end

   // Small-instance monitor
   int s_rd_cnt; logic s_seen; logic [17:0] s_fa_obs;
   always @(negedge clk) begin
      #1;
      if (s_dbg_state == 2'd0) begin
         s_rd_cnt = 0; s_seen = 1'b0;
      end else begin
         if (s_mem_en) begin
            if (!s_seen) begin s_fa_obs = 18'(s_mem_addr); s_seen = 1'b1; end
            s_rd_cnt++;
         end
         if (s_win_valid && s_ready) begin
            chk("s_queue_has_entry", 128'(exp_s_q.size() != 0), 128'd1);
            if (exp_s_q.size() != 0)
               chk_window("s_win", exp_s_q.pop_front(), s_win_x, s_win_y, s_win_data, s_rd_cnt, s_fa_obs);
            n_s_hs++;
            s_rd_cnt = 0; s_seen = 1'b0;
         end
      end
   end

   task automatic chk_idle(input string tag);
      chk({tag, "_state"}, dbg_state, 2'd0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_mem_en"}, mem_en, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr, 18'd0);
      chk({tag, "_win_valid"}, win_valid, 1'b0);
      chk({tag, "_win_data"}, win_data, 108'd0);
      chk({tag, "_win_x"}, win_x, 11'd0);
      chk({tag, "_win_y"}, win_y, 11'd0);
   endtask

   // ---------------- directed sequence ----------------
   int c, dones;
   logic [107:0] d0, corner;

   initial begin
      rst_n = 1'b0; start = 1'b0; win_ready = 1'b1;
      s_start = 1'b0; s_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Corner through interior (5,5), including the row wrap at (511,0) -> (0,1)
      for (int i = 0; i <= 5 * 512 + 5; i++) exp_q.push_back(model(i % 512, i / 512, 512, 384));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      chk("busy_after_start", busy, 1'b1);
      while (!win_valid && c < 20) begin @(negedge clk); c++; end
      chk("first_valid_cycle", c, 11);
      corner = {12'h201, 12'h200, 12'h000, 12'h001, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
      chk("corner_x", win_x, 11'd0);
      chk("corner_y", win_y, 11'd0);
      chk("corner_data", win_data, corner);

      // A start pulse mid-frame must not restart the walk
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Stall the interior window (5,5)
      c = 0;
      while (!(win_x == 11'd5 && win_y == 11'd5) && c < 40000) begin @(negedge clk); c++; end
      chk("reach_5_5_in_time", 128'(c < 40000), 128'd1);
      win_ready = 1'b0;
      c = 0;
      while (!win_valid && c < 20) begin @(negedge clk); c++; end
      chk("valid_5_5_in_time", 128'(c < 20), 128'd1);
      d0 = win_data;
      chk("interior_tap0", d0[0 +: 12], 12'h804);
      chk("interior_tap4", d0[48 +: 12], 12'hA05);
      chk("interior_tap8", d0[96 +: 12], 12'hC06);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_valid", win_valid, 1'b1);
         chk("stall_data", win_data, d0);
         chk("stall_x", win_x, 11'd5);
         chk("stall_y", win_y, 11'd5);
         chk("stall_mem_en", mem_en, 1'b0);
      end
      win_ready = 1'b1;
      @(negedge clk);
      chk("release_x", win_x, 11'd6);
      chk("release_y", win_y, 11'd5);
      chk("release_valid", win_valid, 1'b0);
      chk("queue_drained", exp_q.size(), 0);

      // Abort at FETCH k=4 of (6,5)
      repeat (4) @(negedge clk);
      chk("k4_mem_en", mem_en, 1'b1);
      chk("k4_mem_addr", mem_addr, 18'd2566);
      rst_n = 1'b0;
      @(negedge clk);
      chk_idle("abort");
      rst_n = 1'b1;

      // Restart begins again at (0,0)
      exp_q.push_back(model(0, 0, 512, 384));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (!win_valid && c < 20) begin @(negedge clk); c++; end
      chk("restart_valid_cycle", c, 11);
      @(negedge clk);
      chk("restart_popped", exp_q.size(), 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Full small frame: timing, last window, single done pulse
      for (int i = 0; i < 32; i++) exp_s_q.push_back(model(i % 8, i / 8, 8, 4));
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      c = 1;
      dones = 0;
      while (!s_done && c < 400) begin
         @(negedge clk);
         c++;
         s_start = (c == 100);
      end
      s_start = 1'b0;
      chk("s_done_cycle", c, 353);
      chk("s_busy_in_done", s_busy, 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (s_done) dones++;
         @(negedge clk);
      end
      chk("s_done_pulses", dones, 1);
      chk("s_busy_after", s_busy, 1'b0);
      chk("s_state_after", s_dbg_state, 2'd0);
      chk("s_handshakes", n_s_hs, 32);
      chk("s_queue_empty", exp_s_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
